// File: rtl/gray_ptr_ctrl.sv
// One side of an async FIFO: binary pointer with a registered Gray copy, plus
// full/empty, almost flag and fill level against the other domain's synced Gray pointer.
module gray_ptr_ctrl #(
    parameter int ADDR_WIDTH    = 6,
    parameter bit MODE          = 1'b0,
    parameter int ALMOST_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic [ADDR_WIDTH:0]   sync_gray_ptr,
    output logic                  accept,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   bin_ptr,
    output logic [ADDR_WIDTH:0]   gray_ptr,
    output logic                  flag,
    output logic                  almost_flag,
    output logic [ADDR_WIDTH:0]   level
);

    localparam logic [ADDR_WIDTH:0] DEPTH_P  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] THRESH_P = (ADDR_WIDTH + 1)'(ALMOST_THRESH);

    logic [ADDR_WIDTH:0] bin_next;
    logic [ADDR_WIDTH:0] gray_next;
    logic [ADDR_WIDTH:0] sync_bin;
    logic [ADDR_WIDTH:0] level_next;
    logic                flag_next;
    logic                almost_next;

    assign accept    = inc & ~flag;
    assign addr      = bin_ptr[ADDR_WIDTH-1:0];
    assign bin_next  = bin_ptr + {{ADDR_WIDTH{1'b0}}, accept};
    assign gray_next = bin_next ^ (bin_next >> 1);

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        sync_bin = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            sync_bin[i] = ^(sync_gray_ptr >> i);
        end
    end

    // Flags are computed from the next pointer so a full-rate burst never overshoots.
    always_comb begin
        flag_next   = 1'b0;
        level_next  = '0;
        almost_next = 1'b0;
        if (MODE == 1'b0) begin
            flag_next   = (gray_next == {~sync_gray_ptr[ADDR_WIDTH:ADDR_WIDTH-1],
                                         sync_gray_ptr[ADDR_WIDTH-2:0]});
            level_next  = bin_next - sync_bin;
            almost_next = (level_next >= DEPTH_P - THRESH_P);
        end else begin
            flag_next   = (gray_next == sync_gray_ptr);
            level_next  = sync_bin - bin_next;
            almost_next = (level_next <= THRESH_P);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_ptr     <= '0;
            gray_ptr    <= '0;
            level       <= '0;
            flag        <= MODE;
            almost_flag <= MODE;
        end else begin
            bin_ptr     <= bin_next;
            gray_ptr    <= gray_next;
            level       <= level_next;
            flag        <= flag_next;
            almost_flag <= almost_next;
        end
    end

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Bench for gray_ptr_ctrl: a write-side and a read-side instance (ADDR_WIDTH 6)
// stepped together against an occupancy-count model.
module tb_gray_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_inc = 1'b0, r_inc = 1'b0;
    logic [6:0] w_sync = '0, r_sync = '0;
    logic       w_accept, r_accept;
    logic [5:0] w_addr, r_addr;
    logic [6:0] w_bin, r_bin, w_gray, r_gray, w_level, r_level;
    logic       w_flag, r_flag, w_almost, r_almost;

    int errors = 0;
    int checks = 0;

    // model: operation counts mod 128 for each side
    int  w_cnt = 0, w_other = 0, r_cnt = 0, r_other = 0;
    int  w_exp_level = 0, r_exp_level = 0;
    logic w_exp_flag = 1'b0, w_exp_almost = 1'b0;
    logic r_exp_flag = 1'b1, r_exp_almost = 1'b1;
    logic last_w_acc, last_r_acc;

    gray_ptr_ctrl #(.ADDR_WIDTH(6), .MODE(1'b0), .ALMOST_THRESH(4)) u_wr (
        .clk(clk), .rst_n(rst_n), .inc(w_inc), .sync_gray_ptr(w_sync),
        .accept(w_accept), .addr(w_addr), .bin_ptr(w_bin), .gray_ptr(w_gray),
        .flag(w_flag), .almost_flag(w_almost), .level(w_level)
    );

    gray_ptr_ctrl #(.ADDR_WIDTH(6), .MODE(1'b1), .ALMOST_THRESH(4)) u_rd (
        .clk(clk), .rst_n(rst_n), .inc(r_inc), .sync_gray_ptr(r_sync),
        .accept(r_accept), .addr(r_addr), .bin_ptr(r_bin), .gray_ptr(r_gray),
        .flag(r_flag), .almost_flag(r_almost), .level(r_level)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] gray(input int n);
        logic [6:0] b;
        b = n[6:0];
        return b ^ (b >> 1);
    endfunction

    // One cycle for both instances: drive at negedge, check accept, then check registers after the edge.
    task automatic step(input logic wi, input int wo, input logic ri, input int ro);
        logic exp_wa, exp_ra;
        @(negedge clk);
        w_inc = wi; w_other = wo & 127; w_sync = gray(w_other);
        r_inc = ri; r_other = ro & 127; r_sync = gray(r_other);
        #1;
        exp_wa = wi && !w_exp_flag;
        exp_ra = ri && !r_exp_flag;
        checks++;
        if (w_accept !== exp_wa) begin
            errors++; $display("FAIL w_accept got=%b exp=%b t=%0t", w_accept, exp_wa, $time);
        end
        checks++;
        if (r_accept !== exp_ra) begin
            errors++; $display("FAIL r_accept got=%b exp=%b t=%0t", r_accept, exp_ra, $time);
        end
        last_w_acc = exp_wa;
        last_r_acc = exp_ra;
        if (exp_wa) w_cnt = (w_cnt + 1) & 127;
        if (exp_ra) r_cnt = (r_cnt + 1) & 127;
        w_exp_level  = (w_cnt - w_other) & 127;
        w_exp_flag   = (w_exp_level == 64);
        w_exp_almost = (w_exp_level >= 60);
        r_exp_level  = (r_other - r_cnt) & 127;
        r_exp_flag   = (r_exp_level == 0);
        r_exp_almost = (r_exp_level <= 4);
        @(posedge clk);
        #1;
        checks++;
        if (w_bin !== 7'(w_cnt) || w_gray !== gray(w_cnt) || w_addr !== 6'(w_cnt)) begin
            errors++; $display("FAIL w_ptr got bin=%0d gray=%h addr=%0d exp bin=%0d gray=%h",
                               w_bin, w_gray, w_addr, w_cnt, gray(w_cnt));
        end
        checks++;
        if (w_flag !== w_exp_flag || w_almost !== w_exp_almost || w_level !== 7'(w_exp_level)) begin
            errors++; $display("FAIL w_flags got full=%b afull=%b level=%0d exp %b %b %0d",
                               w_flag, w_almost, w_level, w_exp_flag, w_exp_almost, w_exp_level);
        end
        checks++;
        if (r_bin !== 7'(r_cnt) || r_gray !== gray(r_cnt) || r_addr !== 6'(r_cnt)) begin
            errors++; $display("FAIL r_ptr got bin=%0d gray=%h addr=%0d exp bin=%0d gray=%h",
                               r_bin, r_gray, r_addr, r_cnt, gray(r_cnt));
        end
        checks++;
        if (r_flag !== r_exp_flag || r_almost !== r_exp_almost || r_level !== 7'(r_exp_level)) begin
            errors++; $display("FAIL r_flags got empty=%b aempty=%b level=%0d exp %b %b %0d",
                               r_flag, r_almost, r_level, r_exp_flag, r_exp_almost, r_exp_level);
        end
    endtask

    // Assert reset mid-cycle with inc high and check outputs clear before any edge.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        w_inc = 1'b1; r_inc = 1'b1;
        w_sync = '0;  r_sync = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (w_bin !== 7'd0 || w_gray !== 7'd0 || w_level !== 7'd0 || w_flag !== 1'b0 || w_almost !== 1'b0) begin
            errors++; $display("FAIL w_reset got bin=%0d gray=%h level=%0d full=%b afull=%b exp 0 0 0 0 0",
                               w_bin, w_gray, w_level, w_flag, w_almost);
        end
        checks++;
        if (r_bin !== 7'd0 || r_gray !== 7'd0 || r_level !== 7'd0 || r_flag !== 1'b1 || r_almost !== 1'b1) begin
            errors++; $display("FAIL r_reset got bin=%0d gray=%h level=%0d empty=%b aempty=%b exp 0 0 0 1 1",
                               r_bin, r_gray, r_level, r_flag, r_almost);
        end
        w_cnt = 0; w_other = 0; r_cnt = 0; r_other = 0;
        w_exp_level = 0; r_exp_level = 0;
        w_exp_flag = 1'b0; w_exp_almost = 1'b0;
        r_exp_flag = 1'b1; r_exp_almost = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        w_inc = 1'b0; r_inc = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        step(1'b0, 0, 1'b0, 0);
    endtask

    task automatic test_fill();
        int acc = 0;
        apply_reset();
        for (int i = 0; i < 70; i++) begin
            step(1'b1, 0, 1'b0, 0);
            if (last_w_acc) acc++;
            if (acc == 59 && last_w_acc) begin
                checks++;
                if (w_almost !== 1'b0) begin
                    errors++; $display("FAIL fill_almost_early got=%b exp=0", w_almost);
                end
            end
            if (acc == 60 && last_w_acc) begin
                checks++;
                if (w_almost !== 1'b1) begin
                    errors++; $display("FAIL fill_almost_rise got=%b exp=1", w_almost);
                end
            end
        end
        checks++;
        if (acc != 64) begin
            errors++; $display("FAIL fill_accepts got=%0d exp=64", acc);
        end
        checks++;
        if (w_bin !== 7'd64 || w_gray !== 7'h60 || w_level !== 7'd64 || w_flag !== 1'b1) begin
            errors++; $display("FAIL fill_final got bin=%0d gray=%h level=%0d full=%b exp 64 60 64 1",
                               w_bin, w_gray, w_level, w_flag);
        end
    endtask

    task automatic test_drain();
        int acc = 0;
        apply_reset();
        step(1'b0, 0, 1'b0, 10);
        checks++;
        if (r_flag !== 1'b0 || r_level !== 7'd10 || r_sync !== 7'h0F) begin
            errors++; $display("FAIL drain_start got empty=%b level=%0d sync=%h exp 0 10 0f",
                               r_flag, r_level, r_sync);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 0, 1'b1, 10);
            if (last_r_acc) acc++;
            if (acc == 6 && last_r_acc) begin
                checks++;
                if (r_almost !== 1'b1) begin
                    errors++; $display("FAIL drain_almost got=%b exp=1", r_almost);
                end
            end
        end
        checks++;
        if (acc != 10 || r_flag !== 1'b1 || r_bin !== 7'd10) begin
            errors++; $display("FAIL drain_final got acc=%0d empty=%b bin=%0d exp 10 1 10", acc, r_flag, r_bin);
        end
    endtask

    task automatic test_wrap();
        int acc = 0;
        int guard = 0;
        logic [6:0] prev;
        apply_reset();
        step(1'b0, 0, 1'b0, 1);
        while (acc < 128 && guard < 300) begin
            prev = r_gray;
            step(1'b0, 0, 1'b1, r_cnt + 2);
            guard++;
            if (last_r_acc) begin
                acc++;
                checks++;
                if ($countones(prev ^ r_gray) != 1) begin
                    errors++; $display("FAIL wrap_hamming got prev=%h now=%h exp distance 1", prev, r_gray);
                end
            end
            checks++;
            if (r_flag !== 1'b0) begin
                errors++; $display("FAIL wrap_false_empty got=%b exp=0 after %0d pops", r_flag, acc);
            end
        end
        checks++;
        if (acc != 128 || r_bin !== 7'd0) begin
            errors++; $display("FAIL wrap_final got acc=%0d bin=%0d exp 128 0", acc, r_bin);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 63; i++) step(1'b1, 0, 1'b0, 0);
        step(1'b1, 1, 1'b0, 0);
        checks++;
        if (w_level !== 7'd63 || w_flag !== 1'b0) begin
            errors++; $display("FAIL simul_push_pop got level=%0d full=%b exp 63 0", w_level, w_flag);
        end
        step(1'b1, 1, 1'b0, 0);
        checks++;
        if (w_level !== 7'd64 || w_flag !== 1'b1) begin
            errors++; $display("FAIL simul_push_static got level=%0d full=%b exp 64 1", w_level, w_flag);
        end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        for (int i = 0; i < 30; i++) step(1'b1, 0, 1'b0, 0);
        apply_reset();
        step(1'b1, 0, 1'b0, 0);
        checks++;
        if (w_bin !== 7'd1 || w_gray !== 7'h01) begin
            errors++; $display("FAIL reset_first_push got bin=%0d gray=%h exp 1 01", w_bin, w_gray);
        end
    endtask

    // Legal random traffic: the other side never passes or laps this side.
    task automatic test_random();
        int wo, ro;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            wo = w_other;
            ro = r_other;
            if (((w_cnt - w_other) & 127) > 0 && $urandom_range(0, 99) < 40) wo = w_other + 1;
            if (((r_other - r_cnt) & 127) < 64 && $urandom_range(0, 99) < 60) ro = r_other + 1;
            step(1'($urandom_range(0, 1)), wo, 1'($urandom_range(0, 1)), ro);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout exp finish before 2000000");
        $fatal(1);
    end

endmodule
